datapath_core: RTL and testbench

- 16-bit Mano-style datapath: 8x16 register file, A/B operand buses, function unit (ALU + shifter), bus-D write-back mux.
- Driven each cycle by a 16-bit control word.
- Exports the address bus (A), the data-out bus (B after the constant mux) and the V/C/N/Z status flags.
- Sits under the sequencer/control unit of the simple CPU.

---
 rtl/datapath_pkg.sv | 52 +++++
 rtl/datapath_regfile.sv | 50 +++++
 rtl/datapath_core.sv | 128 ++++++++++++
 tb/tb_datapath_core.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the 16-bit Mano-style datapath: widths, control-word
// field positions, function-select opcodes and the control-word struct.
package datapath_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;

  // Control-word field positions (LSB of each field)
  localparam int CW_DA_LSB = 13;
  localparam int CW_AA_LSB = 10;
  localparam int CW_BA_LSB = 7;
  localparam int CW_MB_BIT = 6;
  localparam int CW_FS_LSB = 2;
  localparam int CW_MD_BIT = 1;
  localparam int CW_RW_BIT = 0;

  // Function-select opcodes
  localparam logic [3:0] FS_TSFA  = 4'b0000;
  localparam logic [3:0] FS_INC   = 4'b0001;
  localparam logic [3:0] FS_ADD   = 4'b0010;
  localparam logic [3:0] FS_ADDC  = 4'b0011;
  localparam logic [3:0] FS_ADDNB = 4'b0100;
  localparam logic [3:0] FS_SUB   = 4'b0101;
  localparam logic [3:0] FS_DEC   = 4'b0110;
  localparam logic [3:0] FS_TSFA2 = 4'b0111;
  localparam logic [3:0] FS_AND   = 4'b1000;
  localparam logic [3:0] FS_OR    = 4'b1001;
  localparam logic [3:0] FS_XOR   = 4'b1010;
  localparam logic [3:0] FS_NOT   = 4'b1011;
  localparam logic [3:0] FS_TSFB  = 4'b1100;
  localparam logic [3:0] FS_SHR   = 4'b1101;
  localparam logic [3:0] FS_SHL   = 4'b1110;
  localparam logic [3:0] FS_ZERO  = 4'b1111;

  // Control word, MSB first, matching the field positions above
  typedef struct packed {
    logic [ADDR_W-1:0] da;
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ba;
    logic              mb;
    logic [3:0]        fs;
    logic              md;
    logic              rw;
  } ctrl_word_t;

  // The lower half of the opcode space goes through the adder
  function automatic logic fs_is_arith(input logic [3:0] fs);
    return ~fs[3];
  endfunction

endpackage

// File: rtl/datapath_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write
// port, synchronous active-high clear of every register.
module datapath_regfile
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data
);

  logic [DATA_W-1:0] rd_arr [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q;
      logic [DATA_W-1:0] reg_d;

      // Next value: load on a write to this address, otherwise hold
      always_comb begin
        reg_d = reg_q;
        if (we && (waddr == ADDR_W'(gi))) begin
          reg_d = wdata;
        end
      end

      // Register storage; reset wins over any pending write
      always_ff @(posedge clk) begin
        if (srst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign rd_arr[gi] = reg_q;
    end
  endgenerate

  // Reads see pre-edge contents; no write forwarding
  assign a_data = rd_arr[a_addr];
  assign b_data = rd_arr[b_addr];

endmodule

// File: rtl/datapath_core.sv
// Mano-style datapath: register file, A/B buses, ALU + shifter function unit,
// bus-D write-back mux and V/C/N/Z status.
// Optional macro DP_STATUS_REG_EN: when defined the status flags are
// registered (one cycle latency, cleared by reset); otherwise combinational.
module datapath_core
  import datapath_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       CTRWRD,
  input  logic [DATA_W-1:0] Cin,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic [DATA_W-1:0] Adrout,
  output logic              V,
  output logic              C,
  output logic              N,
  output logic              Z
);

  ctrl_word_t        cw;
  logic [DATA_W-1:0] a_bus;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] b_bus;
  logic [DATA_W-1:0] d_bus;
  logic [DATA_W-1:0] f_val;
  logic [DATA_W-1:0] y_op;
  logic              cin_op;
  logic [DATA_W:0]   sum;
  logic              v_d;
  logic              c_d;
  logic              n_d;
  logic              z_d;

  assign cw = ctrl_word_t'(CTRWRD);

  datapath_regfile u_regfile (
    .clk    (CLK),
    .srst   (RESET),
    .we     (cw.rw),
    .waddr  (cw.da),
    .wdata  (d_bus),
    .a_addr (cw.aa),
    .b_addr (cw.ba),
    .a_data (a_bus),
    .b_data (rf_b)
  );

  assign b_bus = cw.mb ? Cin : rf_b;

  // Effective second adder operand and carry-in for the arithmetic opcodes
  always_comb begin
    y_op   = '0;
    cin_op = 1'b0;
    case (cw.fs)
      FS_INC:   begin y_op = '0;     cin_op = 1'b1; end
      FS_ADD:   begin y_op = b_bus;  cin_op = 1'b0; end
      FS_ADDC:  begin y_op = b_bus;  cin_op = 1'b1; end
      FS_ADDNB: begin y_op = ~b_bus; cin_op = 1'b0; end
      FS_SUB:   begin y_op = ~b_bus; cin_op = 1'b1; end
      FS_DEC:   begin y_op = '1;     cin_op = 1'b0; end
      default:  begin y_op = '0;     cin_op = 1'b0; end
    endcase
  end

  assign sum = {1'b0, a_bus} + {1'b0, y_op} + {{DATA_W{1'b0}}, cin_op};

  // Function unit result and carry/overflow; non-arithmetic ops clear C and V
  always_comb begin
    f_val = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    if (fs_is_arith(cw.fs)) begin
      f_val = sum[DATA_W-1:0];
      c_d   = sum[DATA_W];
      v_d   = (a_bus[DATA_W-1] == y_op[DATA_W-1]) &&
              (sum[DATA_W-1] != a_bus[DATA_W-1]);
    end else begin
      case (cw.fs)
        FS_AND:  f_val = a_bus & b_bus;
        FS_OR:   f_val = a_bus | b_bus;
        FS_XOR:  f_val = a_bus ^ b_bus;
        FS_NOT:  f_val = ~a_bus;
        FS_TSFB: f_val = b_bus;
        FS_SHR:  f_val = {1'b0, b_bus[DATA_W-1:1]};
        FS_SHL:  f_val = {b_bus[DATA_W-2:0], 1'b0};
        default: f_val = '0;
      endcase
    end
  end

  assign n_d = f_val[DATA_W-1];
  assign z_d = (f_val == '0);

  assign d_bus  = cw.md ? Din : f_val;
  assign Dout   = b_bus;
  assign Adrout = a_bus;

`ifdef DP_STATUS_REG_EN
  logic v_q, c_q, n_q, z_q;

  // Status register captures the current flags on every edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v_q <= 1'b0;
      c_q <= 1'b0;
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      n_q <= n_d;
      z_q <= z_d;
    end
  end

  assign V = v_q;
  assign C = c_q;
  assign N = n_q;
  assign Z = z_q;
`else
  assign V = v_d;
  assign C = c_d;
  assign N = n_d;
  assign Z = z_d;
`endif

endmodule

// File: tb/tb_datapath_core.sv
// Scoreboard bench for datapath_core (default build, combinational flags).
// Stimulus pushes expected bus/flag values from an arithmetic reference
// model; a negedge monitor pops and compares against the DUT outputs.
module tb_datapath_core;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] CTRWRD;
  logic [15:0] Cin;
  logic [15:0] Din;
  logic [15:0] Dout;
  logic [15:0] Adrout;
  logic        V, C, N, Z;

  datapath_core dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .CTRWRD (CTRWRD),
    .Cin    (Cin),
    .Din    (Din),
    .Dout   (Dout),
    .Adrout (Adrout),
    .V      (V),
    .C      (C),
    .N      (N),
    .Z      (Z)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          txn;
    logic [15:0] adr;
    logic [15:0] dout;
    logic        v;
    logic        c;
    logic        n;
    logic        z;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_r [8];
  int          checks = 0;
  int          errors = 0;
  int          txn_cnt = 0;

  // Reference function unit: plain unsigned/signed integer arithmetic
  task automatic ref_fu(input logic [3:0] fs, input logic [15:0] a,
                        input logic [15:0] b, output logic [15:0] f,
                        output logic v, output logic c);
    int u;
    int s;
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    u = 0;
    s = 0;
    f = 16'h0000;
    v = 1'b0;
    c = 1'b0;
    if (fs[3] == 1'b0) begin
      case (fs)
        4'd1: begin u = int'(a) + 1;             s = sa + 1;       end
        4'd2: begin u = int'(a) + int'(b);       s = sa + sb;      end
        4'd3: begin u = int'(a) + int'(b) + 1;   s = sa + sb + 1;  end
        4'd4: begin u = int'(a) + 65535 - int'(b); s = sa - sb - 1; end
        4'd5: begin u = int'(a) + 65536 - int'(b); s = sa - sb;    end
        4'd6: begin u = int'(a) + 65535;         s = sa - 1;       end
        default: begin u = int'(a);              s = sa;           end
      endcase
      f = u[15:0];
      c = (u > 65535);
      v = (s > 32767) || (s < -32768);
    end else begin
      case (fs)
        4'd8:    f = a & b;
        4'd9:    f = a | b;
        4'd10:   f = a ^ b;
        4'd11:   f = ~a;
        4'd12:   f = b;
        4'd13:   f = b / 16'd2;
        4'd14:   f = 16'((int'(b) * 2) % 65536);
        default: f = 16'h0000;
      endcase
    end
  endtask

  // One clock of stimulus: drive, predict, push, advance model after the edge
  task automatic step(input logic rst, input logic [2:0] da, input logic [2:0] aa,
                      input logic [2:0] ba, input logic mb, input logic [3:0] fs,
                      input logic md, input logic rw, input logic [15:0] cin_v,
                      input logic [15:0] din_v);
    exp_t        e;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] f;
    logic        v;
    logic        c;
    RESET  = rst;
    CTRWRD = {da, aa, ba, mb, fs, md, rw};
    Cin    = cin_v;
    Din    = din_v;
    a = model_r[aa];
    b = mb ? cin_v : model_r[ba];
    ref_fu(fs, a, b, f, v, c);
    e.txn  = txn_cnt;
    e.adr  = a;
    e.dout = b;
    e.v    = v;
    e.c    = c;
    e.n    = f[15];
    e.z    = (f == 16'h0000);
    sb_q.push_back(e);
    txn_cnt++;
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < 8; i++) model_r[i] = 16'h0000;
    end else if (rw) begin
      model_r[da] = md ? din_v : f;
    end
    #1;
  endtask

  task automatic load(input logic [2:0] r, input logic [15:0] val);
    step(1'b0, r, 3'd0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1, 16'h0000, val);
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 3'(i), 3'(7 - i), 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
  endtask

  // Monitor: outputs are valid every cycle, so compare one entry per negedge
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [21:0] act;
      logic [21:0] req;
      e = sb_q.pop_front();
      act = {Adrout, V, C, N, Z, 2'b00};
      req = {e.adr, e.v, e.c, e.n, e.z, 2'b00};
      checks++;
      if (Adrout !== e.adr) begin
        errors++;
        $display("FAIL txn %0d adrout: got %h expected %h", e.txn, Adrout, e.adr);
      end
      checks++;
      if (Dout !== e.dout) begin
        errors++;
        $display("FAIL txn %0d dout: got %h expected %h", e.txn, Dout, e.dout);
      end
      checks++;
      if ({V, C, N, Z} !== {e.v, e.c, e.n, e.z}) begin
        errors++;
        $display("FAIL txn %0d flags VCNZ: got %b expected %b", e.txn, {V, C, N, Z},
                 {e.v, e.c, e.n, e.z});
      end
      $display("txn %0d ctrl=%h adr=%h dout=%h VCNZ=%b exp_adr=%h exp_dout=%h exp_VCNZ=%b",
               e.txn, CTRWRD, act[21:6], Dout, act[5:2], req[21:6], e.dout, req[5:2]);
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) model_r[i] = 16'h0000;
    // Initial reset: register contents are unknown beforehand, so nothing is
    // predicted for this cycle
    RESET  = 1'b1;
    CTRWRD = 16'h0000;
    Cin    = 16'h0000;
    Din    = 16'h0000;
    @(posedge CLK);
    #1;

    // Reset with a write pending: write must be dropped
    step(1'b1, 3'd3, 3'd3, 3'd3, 1'b0, 4'd0, 1'b1, 1'b1, 16'h00AA, 16'hBEEF);
    read_all();

    // Load R[i] = i
    for (int i = 0; i < 8; i++) load(3'(i), 16'(i));
    read_all();

    // Add: R1 = R2 + R3
    step(1'b0, 3'd1, 3'd2, 3'd3, 1'b0, 4'b0010, 1'b0, 1'b1, 16'h0000, 16'h0000);
    step(1'b0, 3'd0, 3'd1, 3'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Subtract both ways
    step(1'b0, 3'd0, 3'd4, 3'd5, 1'b0, 4'b0101, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 3'd0, 3'd5, 3'd4, 1'b0, 4'b0101, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Constant operand and signed overflow
    load(3'd0, 16'h7FFF);
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 4'b0010, 1'b0, 1'b1, 16'h0001, 16'h0000);
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Shifts
    load(3'd6, 16'h8000);
    step(1'b0, 3'd4, 3'd0, 3'd6, 1'b0, 4'b1110, 1'b0, 1'b1, 16'h0000, 16'h0000);
    step(1'b0, 3'd0, 3'd4, 3'd6, 1'b0, 4'b1101, 1'b0, 1'b0, 16'h0000, 16'h0000);
    load(3'd6, 16'h0006);
    step(1'b0, 3'd0, 3'd0, 3'd6, 1'b0, 4'b1101, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Wrap-around: FFFF + 1
    load(3'd2, 16'hFFFF);
    step(1'b0, 3'd0, 3'd2, 3'd0, 1'b0, 4'b0001, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 3'd0, 3'd2, 3'd0, 1'b0, 4'b0110, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // RW=0 with MD=1: nothing changes
    step(1'b0, 3'd5, 3'd5, 3'd5, 1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000, 16'h1234);
    read_all();

    // Reset overrides a write
    step(1'b1, 3'd7, 3'd7, 3'd6, 1'b1, 4'b0010, 1'b1, 1'b1, 16'h5A5A, 16'h1234);
    read_all();

    // Randomized traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      logic [15:0] w;
      w = 16'($urandom);
      step(($urandom_range(0, 31) == 0), w[15:13], w[12:10], w[9:7], w[6], w[5:2],
           w[1], w[0], 16'($urandom), 16'($urandom));
    end

    // Drain scoreboard with a bounded wait
    for (int t = 0; t < 5 && sb_q.size() > 0; t++) @(negedge CLK);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
